roi_shift_host: RTL and testbench
=================================

# roi_shift_host

Host-side serial driver for the ROI test harness: it accepts a parallel DIN_N-bit test word and shifts it into the harness's `di` pin. It strobes `stb` to load the word into the ROI and strobes again to capture the ROI output. It then shifts the DOUT_N-bit result back in from the harness's `do` pin and returns it as a parallel response. The block sits on the same clock as the harness and is the initiator for its shift/strobe protocol.

## Interface
- `DIN_N`, default 3: harness input word width; must be ≥2.
- `DOUT_N`, default 1: harness output word width; must be ≥1.
- `clk` in 1: the single clock, shared with the harness.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: a test word is offered.
- `req_ready` out 1: the host accepts a word; high only in IDLE.
- `req_din` in DIN_N: test word, where bit i drives harness `din[i]`.
- `rsp_valid` out 1: a result is available; held high until `rsp_ready`.
- `rsp_ready` in 1: the consumer accepts the result.
- `rsp_dout` out DOUT_N: captured ROI output, where bit i comes from harness `dout[i]`.
- `sdi` out 1: drives harness `di`; registered.
- `stb` out 1: drives harness `stb`; registered.
- `sdo` in 1: from harness `do`; sampled at the rising edge of `clk`.

## Operation
Harness model the block relies on:
- Each edge, `din_shr <= {din_shr, di}`.
- On an edge with `stb` high, `din <= din_shr` and `dout_shr <= dout`.
- Otherwise `dout_shr` shifts left.
- `do = dout_shr[DOUT_N-1]`.

State machine, with W = `req_din` latched on accept:
- IDLE: `req_ready`=1, `sdi`=0, `stb`=0. On `req_valid`&&`req_ready`, latch W and go to SHIFT.
- SHIFT, DIN_N cycles: in cycle k (k=0..DIN_N-1), `sdi` = W[DIN_N-1-k], so the MSB goes first. Then go to SETTLE.
- SETTLE, DIN_N cycles:
  - Re-shift W in the same order.
  - `stb`=1 only in the first SETTLE cycle; this loads `din`=W.
  - The re-shift leaves `din_shr`=W again, which gives the ROI DIN_N-1 cycles to settle.
- CAPTURE, 1 cycle: `stb`=1 and `sdi`=0. The harness reloads `din` with W (unchanged) and latches `dout`.
- UNLOAD, DOUT_N cycles:
  - `stb`=0, `sdi`=0.
  - In cycle k, the sampled `sdo` is written to `rsp_dout`[DOUT_N-1-k].
  - Then go to RESP.
- RESP: `rsp_valid`=1 with `rsp_dout` stable. On `rsp_ready`, go to IDLE on the next cycle.

Rules:
- W is never changed mid-transaction, and `req_din` is ignored outside IDLE.
- `stb` is never high outside the first SETTLE cycle and CAPTURE, so the harness sees exactly two strobes per transaction.

## Timing
- Reset values: state IDLE, `sdi`=0, `stb`=0, `rsp_valid`=0, `rsp_dout`=0. `req_ready`=0 while `rst` is high; it rises after the first clock edge following release.
- Latency: with the accept edge as cycle 0, `rsp_valid` rises in cycle 2·DIN_N+DOUT_N+2, which is 9 with the defaults.
- Throughput: one transaction per 2·DIN_N+DOUT_N+3 cycles when `rsp_ready` is tied high.
- `rsp_ready` may be high before `rsp_valid`; the handshake completes in the first cycle of RESP.
- Reset mid-transaction:
  - The block returns to IDLE immediately and `stb` drops asynchronously.
  - A partial word left in `din_shr` is harmless, because the next transaction shifts a full DIN_N bits before any strobe.
- The bit and strobe counter is `$clog2(max(DIN_N,DOUT_N)+1)` bits wide. It reloads on every state change and never wraps inside a state.

## Structure
- Shared package `roi_shift_pkg`:
  - state enum: IDLE, SHIFT, SETTLE, CAPTURE, UNLOAD, RESP;
  - counter-width function;
  - default DIN_N and DOUT_N constants.
- One sub-module, `roi_shift_piso`: a loadable parallel-in/serial-out register producing `sdi`, with a reload input for the SETTLE re-shift. The FSM, counter and `rsp_dout` assembly stay in the top.

## Test plan
The bench instantiates the harness with the single-FDCE ROI (`din[0]`=CE, `din[1]`=CLR, `din[2]`=D) and uses the defaults.
- W=3'b101 (D=1, CE=1): `sdi` is 1,0,1 in cycles 1–3, `stb` is high in cycles 4 and 7, and `rsp_valid` rises in cycle 9 with `rsp_dout`=1.
- W=3'b100 after the previous result (CE=0): `rsp_dout`=1, because the FF holds its value.
- W=3'b110 (CLR=1): `rsp_dout`=0.
- W=3'b001 after a Q=1 state: `rsp_dout`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles. `rsp_valid` and `rsp_dout` stay stable, `req_ready` stays 0, and a pending `req_valid` is accepted only after the handshake.
- Reset asserted during SETTLE:
  - `stb` falls at once and all outputs take their reset values.
  - After release, W=3'b101 completes with `rsp_dout`=1, and exactly two `stb` pulses are counted in that transaction.

Source files
------------

// File: rtl/roi_shift_pkg.sv
// Shared types and constants for the ROI harness host driver.
package roi_shift_pkg;

  localparam int DIN_N_DEF  = 3;
  localparam int DOUT_N_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETTLE,
    CAPTURE,
    UNLOAD,
    RESP
  } state_t;

  // Width of the per-state bit/strobe counter: holds 0..max(a,b).
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/roi_shift_piso.sv
// Loadable parallel-in/serial-out register driving the harness di pin.
// Keeps a copy of the accepted word so it can be re-shifted without the
// requester holding it.
module roi_shift_piso #(
  parameter int DIN_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             clear,
  input  logic             shift,
  input  logic [DIN_N-1:0] din,
  output logic             sdi
);

  logic [DIN_N-1:0] word_q;
  logic [DIN_N-1:0] sr_q;

  // Word hold and shift register; MSB of the shift register is the serial bit.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here has an async reset so sdi is 0 the moment rst rises.
    if (rst) begin
      word_q <= '0;
      sr_q   <= '0;
    end else if (clear) begin
      sr_q <= '0;
    end else if (load) begin
      // NOTE: non-blocking so both registers see the pre-edge din/word_q.
      word_q <= din;
      sr_q   <= din;
    end else if (reload) begin
      sr_q <= word_q;
    end else if (shift) begin
      sr_q <= {sr_q[DIN_N-2:0], 1'b0};
    end
  end

  assign sdi = sr_q[DIN_N-1];

endmodule

// File: rtl/roi_shift_host.sv
// Host-side serial driver for the ROI test harness: shifts a test word in,
// strobes load and capture, shifts the result back out.
module roi_shift_host
  import roi_shift_pkg::*;
#(
  parameter int DIN_N  = DIN_N_DEF,
  parameter int DOUT_N = DOUT_N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIN_N-1:0]  req_din,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DOUT_N-1:0] rsp_dout,
  output logic              sdi,
  output logic              stb,
  input  logic              sdo
);

  localparam int CW = cnt_width(DIN_N, DOUT_N);

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          init_done;
  logic          last;
  logic          stb_d;
  logic          piso_load, piso_reload, piso_clear, piso_shift;

  roi_shift_piso #(.DIN_N(DIN_N)) u_piso (
    .clk    (clk),
    .rst    (rst),
    .load   (piso_load),
    .reload (piso_reload),
    .clear  (piso_clear),
    .shift  (piso_shift),
    .din    (req_din),
    .sdi    (sdi)
  );

  assign req_ready = (state == IDLE) && init_done;
  assign rsp_valid = (state == RESP);

  // Next-state and one-cycle-ahead control for the PISO and strobe register.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    next_state  = state;
    last        = 1'b0;
    stb_d       = 1'b0;
    piso_load   = 1'b0;
    piso_reload = 1'b0;
    piso_clear  = 1'b0;
    piso_shift  = 1'b0;
    case (state)
      SHIFT, SETTLE: last = (cnt == CW'(DIN_N - 1));
      UNLOAD:        last = (cnt == CW'(DOUT_N - 1));
      default:       last = 1'b0;
    endcase
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          next_state = SHIFT;
          piso_load  = 1'b1;
        end
      end
      SHIFT: begin
        piso_shift = 1'b1;
        if (last) begin
          // Re-present the MSB and strobe in the first SETTLE cycle.
          next_state  = SETTLE;
          piso_reload = 1'b1;
          stb_d       = 1'b1;
        end
      end
      SETTLE: begin
        piso_shift = 1'b1;
        if (last) begin
          next_state = CAPTURE;
          piso_clear = 1'b1;
          stb_d      = 1'b1;
        end
      end
      CAPTURE: next_state = UNLOAD;
      UNLOAD:  if (last) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, per-state counter, strobe and ready-after-reset flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stb       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= next_state;
      stb       <= stb_d;
      init_done <= 1'b1;
      if (next_state != state) begin
        cnt <= '0;
      end else if (state == SHIFT || state == SETTLE || state == UNLOAD) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Assemble the result MSB-first from the sampled harness output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_dout <= '0;
    end else if (state == UNLOAD) begin
      for (int i = 0; i < DOUT_N; i++) begin
        if (CW'(DOUT_N - 1 - i) == cnt) rsp_dout[i] <= sdo;
      end
    end
  end

endmodule

// File: tb/tb_roi_shift_host.sv
// Self-checking bench: host driver against a harness wrapping one FDCE
// (din[0]=CE, din[1]=CLR, din[2]=D, dout[0]=Q).
module tb_roi_shift_host;

  localparam int DIN_N  = 3;
  localparam int DOUT_N = 1;
  localparam int LAT    = 2 * DIN_N + DOUT_N + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DIN_N-1:0]  req_din = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DOUT_N-1:0] rsp_dout;
  logic              sdi, stb, sdo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  roi_shift_host #(.DIN_N(DIN_N), .DOUT_N(DOUT_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din   (req_din),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dout  (rsp_dout),
    .sdi       (sdi),
    .stb       (stb),
    .sdo       (sdo)
  );

  // Harness with the single-FDCE ROI.
  logic [DIN_N-1:0] din_shr = '0;
  logic [DIN_N-1:0] din     = '0;
  logic             dout_shr = 1'b0;
  logic             q        = 1'b0;

  always @(posedge clk) begin
    din_shr <= {din_shr[DIN_N-2:0], sdi};
    if (stb) begin
      din      <= din_shr;
      dout_shr <= q;
    end else begin
      dout_shr <= 1'b0;  // one-bit shift-left
    end
    q <= din[1] ? 1'b0 : (din[0] ? din[2] : q);
  end
  assign sdo = dout_shr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One transaction starting mid-cycle in IDLE. hold=0 raises rsp_ready early.
  task automatic run_txn(input logic [2:0] w, input logic exp, input int hold,
                         input logic pend, input logic [2:0] next_w);
    int   pulses;
    logic e_sdi;
    pulses    = 0;
    req_valid = 1'b1;
    req_din   = w;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_din   = ~w;
    for (int c = 1; c <= LAT; c++) begin
      if (hold == 0 && c == 1) rsp_ready = 1'b1;
      if (c <= DIN_N) e_sdi = w[DIN_N-c];
      else if (c <= 2 * DIN_N) e_sdi = w[2*DIN_N-c];
      else e_sdi = 1'b0;
      check($sformatf("sdi_c%0d", c), sdi, e_sdi);
      check($sformatf("stb_c%0d", c), stb, (c == DIN_N + 1 || c == 2 * DIN_N + 1));
      check($sformatf("rsp_valid_c%0d", c), rsp_valid, (c == LAT));
      check($sformatf("req_ready_c%0d", c), req_ready, 0);
      if (stb) pulses++;
      if (c < LAT) begin @(posedge clk); #1; end
    end
    check("stb_pulses", pulses, 2);
    check($sformatf("rsp_dout_w%b", w), rsp_dout, exp);
    if (pend) begin
      req_valid = 1'b1;
      req_din   = next_w;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_dout", rsp_dout, exp);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  typedef struct {
    logic [2:0] w;
    logic       exp;
    int         hold;
    logic       pend;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{w: 3'b101, exp: 1'b1, hold: 1, pend: 1'b0};
    vecs[1] = '{w: 3'b100, exp: 1'b1, hold: 5, pend: 1'b1};  // CE=0 holds Q
    vecs[2] = '{w: 3'b110, exp: 1'b0, hold: 0, pend: 1'b0};  // CLR
    vecs[3] = '{w: 3'b101, exp: 1'b1, hold: 1, pend: 1'b0};  // Q back to 1
    vecs[4] = '{w: 3'b001, exp: 1'b0, hold: 1, pend: 1'b0};  // load D=0

    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_stb", stb, 0);
    check("rst_sdi", sdi, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_dout", rsp_dout, 0);
    @(negedge clk); rst = 1'b0;
    check("release_req_ready", req_ready, 0);
    @(posedge clk); #1;
    check("first_edge_req_ready", req_ready, 1);

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].w, vecs[i].exp, vecs[i].hold, vecs[i].pend,
              (i < 4) ? vecs[i+1].w : 3'b000);
    end

    // Reset during the first SETTLE cycle while stb is high.
    req_valid = 1'b1;
    req_din   = 3'b101;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (DIN_N) begin @(posedge clk); #1; end
    check("settle_stb_before_rst", stb, 1);
    rst = 1'b1;
    #1;
    check("midrst_stb", stb, 0);
    check("midrst_sdi", sdi, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_dout", rsp_dout, 0);
    check("midrst_req_ready", req_ready, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_release_ready", req_ready, 1);
    run_txn(3'b101, 1'b1, 1, 1'b0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
